uart_slip_rx_decoder: RTL and testbench

- Sits directly downstream of the fast UART receive driver in the clk (50 MHz) domain and consumes its byte pulses (out/out_ready feed our in/in_ready).
- Decodes SLIP framing (END 0xC0, ESC 0xDB, ESC_END 0xDC, ESC_ESC 0xDD) into a framed byte stream with start/end markers, a length count and error flagging.
- Feeds the Ethernet-frame buffering/decrypt path.

---
 rtl/uart_slip_rx_decoder.sv | 144 ++++++++++++++
 tb/tb_uart_slip_rx_decoder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/uart_slip_rx_decoder.sv
// SLIP receive decoder: turns raw UART byte pulses into framed payload beats with length and error flags.
// Define UART_SLIP_HUNT_EN to start in HUNT after reset and ignore bytes until the first END.
module uart_slip_rx_decoder #(
    parameter int MAX_LEN = 1536,
    parameter int LEN_W   = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_ready,
    input  logic [7:0]       in,
    output logic             out_ready,
    output logic [7:0]       out,
    output logic             out_start,
    output logic             out_end,
    output logic             frame_done,
    output logic             frame_err,
    output logic [LEN_W-1:0] frame_len
);
    localparam logic [7:0] END     = 8'hC0;
    localparam logic [7:0] ESC     = 8'hDB;
    localparam logic [7:0] ESC_END = 8'hDC;
    localparam logic [7:0] ESC_ESC = 8'hDD;
    localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {HUNT, DATA, ESC_ST, DISCARD} state_t;

`ifdef UART_SLIP_HUNT_EN
    localparam state_t RESET_STATE = HUNT;
`else
    localparam state_t RESET_STATE = DATA;
`endif

    state_t           state, state_n, err_next;
    logic [7:0]       hold, hold_n, dec;
    logic             hold_valid, hold_valid_n, hold_first, hold_first_n;
    logic [LEN_W-1:0] count, count_n, len_p;
    logic             dec_vld, proto_err, emit, emit_end, done_p, err_p;

    always_comb begin
        state_n      = state;
        hold_n       = hold;
        hold_valid_n = hold_valid;
        hold_first_n = hold_first;
        count_n      = count;
        dec          = 8'h00;
        dec_vld      = 1'b0;
        proto_err    = 1'b0;
        err_next     = DISCARD;
        emit         = 1'b0;
        emit_end     = 1'b0;
        done_p       = 1'b0;
        err_p        = 1'b0;
        len_p        = '0;
        if (in_ready) begin
            case (state)
                HUNT: if (in == END) state_n = DATA;
                DATA: begin
                    if (in == END) begin
                        // Empty frames (hold empty) close silently.
                        emit         = hold_valid;
                        emit_end     = hold_valid;
                        done_p       = hold_valid;
                        len_p        = hold_valid ? count : '0;
                        hold_valid_n = 1'b0;
                        count_n      = '0;
                    end else if (in == ESC) begin
                        state_n = ESC_ST;
                    end else begin
                        dec     = in;
                        dec_vld = 1'b1;
                    end
                end
                ESC_ST: begin
                    state_n = DATA;
                    if (in == ESC_END) begin
                        dec     = END;
                        dec_vld = 1'b1;
                    end else if (in == ESC_ESC) begin
                        dec     = ESC;
                        dec_vld = 1'b1;
                    end else begin
                        // END here still resynchronises, so skip DISCARD.
                        proto_err = 1'b1;
                        err_next  = (in == END) ? DATA : DISCARD;
                    end
                end
                default: if (in == END) state_n = DATA;
            endcase

            if (dec_vld) begin
                if (count == MAX_CNT) begin
                    proto_err = 1'b1;
                    err_next  = DISCARD;
                end else begin
                    emit         = hold_valid;
                    hold_n       = dec;
                    hold_valid_n = 1'b1;
                    hold_first_n = (count == '0);
                    count_n      = count + LEN_W'(1);
                end
            end

            if (proto_err) begin
                emit         = hold_valid;
                emit_end     = hold_valid;
                err_p        = 1'b1;
                len_p        = hold_valid ? count : '0;
                hold_valid_n = 1'b0;
                count_n      = '0;
                state_n      = err_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RESET_STATE;
            hold       <= 8'h00;
            hold_valid <= 1'b0;
            hold_first <= 1'b0;
            count      <= '0;
            out_ready  <= 1'b0;
            out        <= 8'h00;
            out_start  <= 1'b0;
            out_end    <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            frame_len  <= '0;
        end else begin
            state      <= state_n;
            hold       <= hold_n;
            hold_valid <= hold_valid_n;
            hold_first <= hold_first_n;
            count      <= count_n;
            out_ready  <= emit;
            out_start  <= emit & hold_first;
            out_end    <= emit_end;
            frame_done <= done_p;
            frame_err  <= err_p;
            if (emit) out <= hold;
            if (done_p || err_p) frame_len <= len_p;
        end
    end
endmodule

// File: tb/tb_uart_slip_rx_decoder.sv
// Directed bench for uart_slip_rx_decoder: default-size instance plus a MAX_LEN=4 instance for overflow.
module tb_uart_slip_rx_decoder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_ready = 1'b0;
    logic [7:0]  in_b = 8'h00;

    logic        a_rdy, a_st, a_en, a_dn, a_er;
    logic [7:0]  a_out;
    logic [10:0] a_len;
    logic        b_rdy, b_st, b_en, b_dn, b_er;
    logic [7:0]  b_out;
    logic [2:0]  b_len;

    int checks = 0;
    int failures = 0;
    logic [23:0] qa[$];
    logic [23:0] qb[$];

    uart_slip_rx_decoder dut_a (
        .clk(clk), .reset(reset), .in_ready(in_ready), .in(in_b),
        .out_ready(a_rdy), .out(a_out), .out_start(a_st), .out_end(a_en),
        .frame_done(a_dn), .frame_err(a_er), .frame_len(a_len)
    );

    uart_slip_rx_decoder #(.MAX_LEN(4), .LEN_W(3)) dut_b (
        .clk(clk), .reset(reset), .in_ready(in_ready), .in(in_b),
        .out_ready(b_rdy), .out(b_out), .out_start(b_st), .out_end(b_en),
        .frame_done(b_dn), .frame_err(b_er), .frame_len(b_len)
    );

    always #10 clk = ~clk;

    // Beat record: {out_ready, out, start, end, done, err, len}; out/len masked when not qualified.
    function automatic logic [23:0] pk(input logic r, input logic [7:0] o, input logic s, input logic e,
                                       input logic d, input logic er, input logic [10:0] l);
        return {r, r ? o : 8'h00, s, e, d, er, (d | er) ? l : 11'h000};
    endfunction

    function automatic logic [23:0] bt(input logic [7:0] b, input logic s, input logic e,
                                       input logic d, input logic er, input logic [10:0] l);
        return {1'b1, b, s, e, d, er, l};
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (a_rdy || a_dn || a_er) qa.push_back(pk(a_rdy, a_out, a_st, a_en, a_dn, a_er, a_len));
            if (b_rdy || b_dn || b_er) qb.push_back(pk(b_rdy, b_out, b_st, b_en, b_dn, b_er, {8'h00, b_len}));
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cmp(input string tag, input logic [23:0] got[$], input logic [23:0] exp[$]);
        chk($sformatf("%s_count", tag), got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), (i < got.size()) ? {8'h00, got[i]} : 32'hFFFFFFFF, {8'h00, exp[i]});
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) begin
            @(negedge clk);
            in_b = s[i];
            in_ready = 1'b1;
        end
        @(negedge clk);
        in_ready = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rdy"}, a_rdy, 0);
        chk({tag, "_out"}, a_out, 0);
        chk({tag, "_flags"}, {a_st, a_en, a_dn, a_er}, 0);
        chk({tag, "_len"}, a_len, 0);
    endtask

    initial begin
        logic [7:0]  s[$];
        logic [23:0] e[$];

        do_reset();
        chk_zero("reset");
        reset = 1'b0;

        // Basic frame.
        qa.delete();
        s = '{8'hC0, 8'h11, 8'h22, 8'h33, 8'hC0};
        send_seq(s);
        e = '{bt(8'h11,1,0,0,0,0), bt(8'h22,0,0,0,0,0), bt(8'h33,0,1,1,0,3)};
        cmp("basic", qa, e);
        chk("len_hold", a_len, 3);

        // Escapes.
        qa.delete();
        s = '{8'hC0, 8'hDB, 8'hDC, 8'hDB, 8'hDD, 8'h05, 8'hC0};
        send_seq(s);
        e = '{bt(8'hC0,1,0,0,0,0), bt(8'hDB,0,0,0,0,0), bt(8'h05,0,1,1,0,3)};
        cmp("escape", qa, e);

        // Bad escape, discard, resync.
        qa.delete();
        s = '{8'hC0, 8'hAA, 8'hDB, 8'h41, 8'h77, 8'h88, 8'hC0, 8'h44, 8'hC0};
        send_seq(s);
        e = '{bt(8'hAA,1,1,0,1,1), bt(8'h44,1,1,1,0,1)};
        cmp("badesc", qa, e);

        // END inside escape: error, then straight back to DATA.
        qa.delete();
        s = '{8'hC0, 8'hAB, 8'hDB, 8'hC0, 8'h5A, 8'hC0};
        send_seq(s);
        e = '{bt(8'hAB,1,1,0,1,1), bt(8'h5A,1,1,1,0,1)};
        cmp("escend", qa, e);

        // Error with empty hold: lone frame_err, len 0.
        qa.delete();
        s = '{8'hC0, 8'hDB, 8'h41, 8'h66, 8'hC0, 8'h7E, 8'hC0};
        send_seq(s);
        e = '{{1'b0, 8'h00, 4'b0001, 11'h000}, bt(8'h7E,1,1,1,0,1)};
        cmp("emptyerr", qa, e);

        // Overflow on the MAX_LEN=4 instance.
        qb.delete();
        s = '{8'hC0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hC0};
        send_seq(s);
        e = '{bt(8'h01,1,0,0,0,0), bt(8'h02,0,0,0,0,0), bt(8'h03,0,0,0,0,0), bt(8'h04,0,1,0,1,4)};
        cmp("overflow", qb, e);

        // Exactly MAX_LEN bytes is a good frame.
        qb.delete();
        s = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'hC0};
        send_seq(s);
        e = '{bt(8'h0A,1,0,0,0,0), bt(8'h0B,0,0,0,0,0), bt(8'h0C,0,0,0,0,0), bt(8'h0D,0,1,1,0,4)};
        cmp("maxlen", qb, e);

        // Empty frames and start-up hunt, back-to-back strobes.
        do_reset();
        reset = 1'b0;
        qa.delete();
        s = '{8'h99, 8'hC0, 8'hC0, 8'hC0, 8'h55, 8'hC0};
        send_seq(s);
`ifdef UART_SLIP_HUNT_EN
        e = '{bt(8'h55,1,1,1,0,1)};
`else
        e = '{bt(8'h99,1,1,1,0,1), bt(8'h55,1,1,1,0,1)};
`endif
        cmp("hunt", qa, e);

        // Reset mid-frame drops the held byte.
        s = '{8'hC0, 8'h10, 8'h20};
        send_seq(s);
        do_reset();
        chk_zero("midreset");
        reset = 1'b0;
        qa.delete();
        s = '{8'hC0, 8'h30, 8'hC0};
        send_seq(s);
        e = '{bt(8'h30,1,1,1,0,1)};
        cmp("afterreset", qa, e);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
